// File: rtl/sega_pad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sega_pad_pkg
//  Purpose  : Shared constants for the SMS / Mega Drive pad scanner: pad type
//             codes, decoded-word bit positions, pad pin positions, scan
//             phase numbers and the pad classification helper.
//  Revision : 1.0 - initial release
// ============================================================================
package sega_pad_pkg;

    // Pad type codes reported on pad_type
    localparam logic [1:0] PAD_NONE = 2'd0;
    localparam logic [1:0] PAD_3BTN = 2'd1;
    localparam logic [1:0] PAD_6BTN = 2'd2;
    localparam logic [1:0] PAD_ERR  = 2'd3;

    // Bit positions inside the decoded word {Z,Y,X,M,S,C,B,A,U,D,L,R}
    localparam int BTN_R = 0;
    localparam int BTN_L = 1;
    localparam int BTN_D = 2;
    localparam int BTN_U = 3;
    localparam int BTN_A = 4;
    localparam int BTN_B = 5;
    localparam int BTN_C = 6;
    localparam int BTN_S = 7;
    localparam int BTN_M = 8;
    localparam int BTN_X = 9;
    localparam int BTN_Y = 10;
    localparam int BTN_Z = 11;

    // Bit positions inside one pad port {pin9,pin6,up,down,left,right}
    localparam int PIN_R = 0;
    localparam int PIN_L = 1;
    localparam int PIN_D = 2;
    localparam int PIN_U = 3;
    localparam int PIN_6 = 4;
    localparam int PIN_9 = 5;

    // Scan phases that carry a sample (even phases drive select high)
    localparam logic [2:0] PH_P0   = 3'd0;  // C, B, U, D, L, R
    localparam logic [2:0] PH_P1   = 3'd1;  // S, A, first L+R-low marker
    localparam logic [2:0] PH_SIX  = 3'd3;  // all-directions-low 6-button marker
    localparam logic [2:0] PH_ZYXM = 3'd4;  // Z, Y, X, M
    localparam logic [2:0] PH_LAST = 3'd7;  // second L+R-low marker

    // Classify a pad from its two L+R-low markers and the 6-button marker.
    // Disagreeing markers mean the pad changed mid-frame.
    function automatic logic [1:0] classify_pad(input logic md1,
                                                input logic md7,
                                                input logic six);
        if (md1 != md7)
            return PAD_ERR;
        else if (!md1)
            return PAD_NONE;
        else if (six)
            return PAD_6BTN;
        else
            return PAD_3BTN;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sega_pad_decode.sv
`default_nettype none
// ============================================================================
//  Module   : sega_pad_decode
//  Purpose  : Per-pad sample capture, pad type detection and button decode.
//             Option SEGA_PAD_DEBOUNCE_EN: outputs follow a frame's result
//             only when it matches the previous frame's result.
//  Revision : 1.0 - initial release
// ============================================================================
module sega_pad_decode
    import sega_pad_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_sample,       // last cycle of the current phase
    input  logic [2:0]  i_phase,
    input  logic [5:0]  i_pins,         // synchronised, active low
    output logic [1:0]  o_pad_type,
    output logic [11:0] o_pad_decoded
);

    logic [5:0]  w_btn;
    logic        w_md7;
    logic        w_commit;
    logic [1:0]  w_type;
    logic [11:0] w_word;

    logic [5:0]  r_p0;      // phase-0 levels, active high
    logic [1:0]  r_sa;      // {S, A}
    logic        r_md1;
    logic        r_six;
    logic [3:0]  r_zyxm;

    assign w_btn    = ~i_pins;
    assign w_md7    = w_btn[PIN_L] & w_btn[PIN_R];
    assign w_commit = i_sample && (i_phase == PH_LAST);

    // Capture the pins of each sampled phase as the frame progresses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p0   <= '0;
            r_sa   <= '0;
            r_md1  <= 1'b0;
            r_six  <= 1'b0;
            r_zyxm <= '0;
        end else if (i_sample) begin
            case (i_phase)
                PH_P0:   r_p0   <= w_btn;
                PH_P1: begin
                    r_sa  <= {w_btn[PIN_9], w_btn[PIN_6]};
                    r_md1 <= w_btn[PIN_L] & w_btn[PIN_R];
                end
                PH_SIX:  r_six  <= &w_btn[PIN_U:PIN_R];
                PH_ZYXM: r_zyxm <= w_btn[PIN_U:PIN_R];
                default: ;
            endcase
        end
    end

    // Build this frame's type and word; the last marker comes live from phase 7
    always_comb begin
        w_type = classify_pad(r_md1, w_md7, r_six);
        w_word = '0;
        case (w_type)
            PAD_NONE: begin
                w_word[BTN_C]       = r_p0[PIN_9];
                w_word[BTN_B]       = r_p0[PIN_6];
                w_word[BTN_U:BTN_R] = r_p0[PIN_U:PIN_R];
            end
            PAD_3BTN: begin
                w_word[BTN_S]       = r_sa[1];
                w_word[BTN_C]       = r_p0[PIN_9];
                w_word[BTN_B]       = r_p0[PIN_6];
                w_word[BTN_A]       = r_sa[0];
                w_word[BTN_U:BTN_R] = r_p0[PIN_U:PIN_R];
            end
            PAD_6BTN: begin
                w_word[BTN_Z:BTN_M] = r_zyxm;
                w_word[BTN_S]       = r_sa[1];
                w_word[BTN_C]       = r_p0[PIN_9];
                w_word[BTN_B]       = r_p0[PIN_6];
                w_word[BTN_A]       = r_sa[0];
                w_word[BTN_U:BTN_R] = r_p0[PIN_U:PIN_R];
            end
            default: w_word = o_pad_decoded;   // error frame keeps old buttons
        endcase
    end

`ifdef SEGA_PAD_DEBOUNCE_EN
    logic [1:0]  r_raw_type;
    logic [11:0] r_raw_word;

    // Accept a frame's result only when the previous frame produced the same
    always_ff @(posedge clk) begin
        if (rst) begin
            r_raw_type    <= PAD_NONE;
            r_raw_word    <= '0;
            o_pad_type    <= PAD_NONE;
            o_pad_decoded <= '0;
        end else if (w_commit) begin
            r_raw_type <= w_type;
            r_raw_word <= w_word;
            if ((w_type == r_raw_type) && (w_word == r_raw_word)) begin
                o_pad_type    <= w_type;
                o_pad_decoded <= w_word;
            end
        end
    end
`else
    // Outputs follow every completed frame
    always_ff @(posedge clk) begin
        if (rst) begin
            o_pad_type    <= PAD_NONE;
            o_pad_decoded <= '0;
        end else if (w_commit) begin
            o_pad_type    <= w_type;
            o_pad_decoded <= w_word;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/sega_pad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : sega_pad_scanner
//  Purpose  : Multi-port SMS / Mega Drive pad scanner. One select sequencer
//             drives all ports; each port has its own decoder.
//             Option SEGA_PAD_DEBOUNCE_EN: two-frame agreement before the
//             decoded word and type change (frame_done still every frame).
//  Revision : 1.0 - initial release
// ============================================================================
module sega_pad_scanner
    import sega_pad_pkg::*;
#(
    parameter int N_PADS     = 2,
    parameter int SETTLE_CYC = 500,
    parameter int POLL_CYC   = 833333
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [6*N_PADS-1:0]   pad_in,
    output logic [N_PADS-1:0]     pad_sel,
    output logic [2*N_PADS-1:0]   pad_type,
    output logic [12*N_PADS-1:0]  pad_decoded,
    output logic                  frame_done
);

    localparam int c_poll_w = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
    localparam int c_set_w  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [c_poll_w-1:0] c_poll_last = c_poll_w'(POLL_CYC - 1);
    localparam logic [c_set_w-1:0]  c_set_last  = c_set_w'(SETTLE_CYC - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_scan = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [6*N_PADS-1:0] r_meta;
    logic [6*N_PADS-1:0] r_sync;
    logic [c_poll_w-1:0] r_poll_cnt;
    logic [1:0]          r_state;
    logic [2:0]          r_phase;
    logic [c_set_w-1:0]  r_settle;
    logic                r_sel;
    logic                r_frame_done;
    logic                w_wrap;
    logic                w_phase_end;

    assign w_wrap      = (r_poll_cnt == c_poll_last);
    assign w_phase_end = (r_state == c_st_scan) && (r_settle == c_set_last);
    assign pad_sel     = {N_PADS{r_sel}};
    assign frame_done  = r_frame_done;

    // Two-flop synchroniser for the asynchronous pad pins (idle level high)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= pad_in;
            r_sync <= r_meta;
        end
    end

    // Free-running frame-rate counter
    always_ff @(posedge clk) begin
        if (reset)
            r_poll_cnt <= '0;
        else if (w_wrap)
            r_poll_cnt <= '0;
        else
            r_poll_cnt <= r_poll_cnt + c_poll_w'(1);
    end

    // Select sequencer: 8 phases per frame, select high on even phases
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_phase      <= PH_P0;
            r_settle     <= '0;
            r_sel        <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_sel <= 1'b1;
                    if (w_wrap && en) begin
                        r_state  <= c_st_scan;
                        r_phase  <= PH_P0;
                        r_settle <= '0;
                    end
                end
                c_st_scan: begin
                    if (w_phase_end) begin
                        r_settle <= '0;
                        if (r_phase == PH_LAST) begin
                            r_state      <= c_st_done;
                            r_sel        <= 1'b1;
                            r_frame_done <= 1'b1;   // outputs update on this edge
                        end else begin
                            r_phase <= r_phase + 3'd1;
                            r_sel   <= r_phase[0];  // level for the next phase
                        end
                    end else begin
                        r_settle <= r_settle + c_set_w'(1);
                    end
                end
                c_st_done: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < N_PADS; g++) begin : g_pad
            sega_pad_decode u_decode (
                .clk           (clk),
                .rst           (reset),
                .i_sample      (w_phase_end),
                .i_phase       (r_phase),
                .i_pins        (r_sync[6*g +: 6]),
                .o_pad_type    (pad_type[2*g +: 2]),
                .o_pad_decoded (pad_decoded[12*g +: 12])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sega_pad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sega_pad_scanner
//  Purpose  : Scoreboard bench with behavioural pad models (none, SMS,
//             3-button, 6-button, 6-button unplugged mid-frame).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sega_pad_scanner;

    localparam int N    = 2;
    localparam int SET  = 4;
    localparam int POLL = 64;

    localparam int K_NONE   = 0;
    localparam int K_SMS    = 1;
    localparam int K_3B     = 2;
    localparam int K_6B     = 3;
    localparam int K_UNPLUG = 4;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              en    = 1'b0;
    logic [6*N-1:0]    pad_in;
    logic [N-1:0]      pad_sel;
    logic [2*N-1:0]    pad_type;
    logic [12*N-1:0]   pad_decoded;
    logic              frame_done;

    sega_pad_scanner #(.N_PADS(N), .SETTLE_CYC(SET), .POLL_CYC(POLL)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .pad_in      (pad_in),
        .pad_sel     (pad_sel),
        .pad_type    (pad_type),
        .pad_decoded (pad_decoded),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- pad models ----------------
    int          pad_kind [N];
    logic [11:0] pad_btn  [N];
    int          lowcnt = 0;   // select-low phases seen this frame

    always @(negedge pad_sel[0] or posedge frame_done or posedge reset) begin
        if (reset || frame_done) lowcnt <= 0;
        else                     lowcnt <= lowcnt + 1;
    end

    // Pin levels {pin9,pin6,U,D,L,R} (active low) of one pad
    function automatic logic [5:0] pins(input int kind, input logic [11:0] b,
                                        input logic sel, input int lc);
        logic [5:0] act;
        int k;
        act = 6'b0;
        k = kind;
        if (kind == K_UNPLUG)
            k = (lc == 0 || (lc == 1 && !sel)) ? K_6B : K_NONE;
        case (k)
            K_SMS: act = {b[6], b[5], b[3:0]};
            K_3B, K_6B: begin
                if (sel) begin
                    act = {b[6], b[5], b[3:0]};
                    if (k == K_6B && lc == 2) act[3:0] = b[11:8];
                end else begin
                    act = {b[7], b[4], b[3], b[2], 1'b1, 1'b1};
                    if (k == K_6B && lc == 2) act[3:0] = 4'hF;
                end
            end
            default: act = 6'b0;
        endcase
        return ~act;
    endfunction

    always_comb begin
        pad_in = '1;
        for (int p = 0; p < N; p++)
            pad_in[6*p +: 6] = pins(pad_kind[p], pad_btn[p], pad_sel[0], lowcnt);
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [2*N-1:0]  t;
        logic [12*N-1:0] d;
    } exp_t;

    exp_t        q[$];
    logic [1:0]  m_type  [N];
    logic [11:0] m_dec   [N];
    logic [1:0]  m_raw_t [N];
    logic [11:0] m_raw_d [N];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < N; p++) begin
            m_type[p] = 2'd0;  m_dec[p] = 12'd0;
            m_raw_t[p] = 2'd0; m_raw_d[p] = 12'd0;
        end
    endtask

    // Expected outputs after the next frame, from what each pad is and holds
    task automatic predict_frame();
        exp_t        e;
        logic [1:0]  t;
        logic [11:0] d;
        for (int p = 0; p < N; p++) begin
            case (pad_kind[p])
                K_NONE:  begin t = 2'd0; d = 12'd0; end
                K_SMS:   begin t = 2'd0; d = pad_btn[p] & 12'h06F; end
                K_3B:    begin t = 2'd1; d = pad_btn[p] & 12'h0FF; end
                K_6B:    begin t = 2'd2; d = pad_btn[p]; end
                default: begin t = 2'd3; d = m_dec[p]; end
            endcase
`ifdef SEGA_PAD_DEBOUNCE_EN
            if (t == m_raw_t[p] && d == m_raw_d[p]) begin
                m_type[p] = t; m_dec[p] = d;
            end
            m_raw_t[p] = t; m_raw_d[p] = d;
`else
            m_type[p] = t; m_dec[p] = d;
`endif
            e.t[2*p +: 2]   = m_type[p];
            e.d[12*p +: 12] = m_dec[p];
        end
        q.push_back(e);
    endtask

    function automatic logic [31:0] pack_t();
        logic [31:0] r = 0;
        for (int p = 0; p < N; p++) r[2*p +: 2] = m_type[p];
        return r;
    endfunction

    function automatic logic [31:0] pack_d();
        logic [31:0] r = 0;
        for (int p = 0; p < N; p++) r[12*p +: 12] = m_dec[p];
        return r;
    endfunction

    // Buttons without physically impossible opposing directions
    function automatic logic [11:0] rand_btn();
        logic [11:0] b;
        b = 12'($urandom);
        if (b[3] && b[2]) b[2] = 1'b0;
        if (b[1] && b[0]) b[0] = 1'b0;
        return b;
    endfunction

    // Monitor: compare every frame_done against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (frame_done === 1'b1) begin
                if (q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_frame_done: got frame_done=1, expected no frame");
                end else begin
                    e = q.pop_front();
                    check("pad_type", 32'(pad_type), 32'(e.t));
                    check("pad_decoded", 32'(pad_decoded), 32'(e.d));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_frame();
        int i;
        i = 0;
        tick();
        while (frame_done !== 1'b1 && i < 3*POLL) begin tick(); i++; end
        if (frame_done !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL frame_timeout: got no frame_done in %0d cycles, expected one", 3*POLL);
        end
    endtask

    task automatic wait_toggles(input int n);
        int   seen;
        int   i;
        logic prev;
        seen = 0; i = 0; prev = pad_sel[0];
        while (seen < n && i < 3*POLL) begin
            tick(); i++;
            if (pad_sel[0] !== prev) seen++;
            prev = pad_sel[0];
        end
        if (seen < n) begin
            n_tests++; n_fail++;
            $display("FAIL sel_toggle_timeout: got %0d toggles, expected %0d", seen, n);
        end
    endtask

    task automatic set_pad(input int p, input int kind, input logic [11:0] b);
        pad_kind[p] = kind;
        pad_btn[p]  = b;
    endtask

    initial begin
        int         t0;
        int         toggles;
        int         dones;
        logic [N-1:0] prev;

        for (int p = 0; p < N; p++) set_pad(p, K_6B, 12'h000);
        model_reset();
        reset = 1'b1; en = 1'b1;
        repeat (3) tick();
        check("reset_pad_sel", 32'(pad_sel), 32'({N{1'b1}}));
        check("reset_pad_type", 32'(pad_type), 32'd0);
        check("reset_pad_decoded", 32'(pad_decoded), 32'd0);
        check("reset_frame_done", 32'(frame_done), 32'd0);

        // idle 6-button pads, frame rate
        predict_frame();
        reset = 1'b0;
        wait_frame();
        t0 = cyc;
        check("idle_pad_sel", 32'(pad_sel), 32'({N{1'b1}}));
        predict_frame();
        wait_frame();
        check("frame_period", 32'(cyc - t0), 32'(POLL));

        // directed pads
        set_pad(0, K_3B, 12'h090);  set_pad(1, K_NONE, 12'h000); predict_frame(); wait_frame();
        set_pad(0, K_SMS, 12'h020); set_pad(1, K_6B, rand_btn()); predict_frame(); wait_frame();
        set_pad(0, K_6B, 12'h5A6);  set_pad(1, K_3B, rand_btn()); predict_frame(); wait_frame();
        set_pad(0, K_UNPLUG, rand_btn()); set_pad(1, K_SMS, rand_btn()); predict_frame(); wait_frame();
        set_pad(0, K_6B, 12'h811);  predict_frame(); wait_frame();
        set_pad(0, K_6B, 12'h811);  predict_frame(); wait_frame();

        // random pads
        for (int f = 0; f < 12; f++) begin
            for (int p = 0; p < N; p++) set_pad(p, int'($urandom_range(0, 4)), rand_btn());
            predict_frame();
            wait_frame();
        end

        // en dropped mid-frame: frame completes, then nothing until en returns
        for (int p = 0; p < N; p++) set_pad(p, K_6B, rand_btn());
        predict_frame();
        wait_toggles(1);
        en = 1'b0;
        wait_frame();
        prev = pad_sel; toggles = 0; dones = 0;
        repeat (2*POLL) begin
            tick();
            if (pad_sel !== prev) toggles++;
            prev = pad_sel;
            if (frame_done === 1'b1) dones++;
        end
        check("en0_sel_toggles", 32'(toggles), 32'd0);
        check("en0_frame_done", 32'(dones), 32'd0);
        check("en0_hold_type", 32'(pad_type), pack_t());
        check("en0_hold_decoded", 32'(pad_decoded), pack_d());
        en = 1'b1;
        predict_frame();
        wait_frame();

        // reset during phase 4
        for (int p = 0; p < N; p++) set_pad(p, K_6B, rand_btn() | 12'h010);
        predict_frame();
        wait_frame();
        predict_frame();
        wait_frame();
        wait_toggles(4);
        tick();
        reset = 1'b1;
        tick();
        check("abort_pad_sel", 32'(pad_sel), 32'({N{1'b1}}));
        check("abort_pad_type", 32'(pad_type), 32'd0);
        check("abort_pad_decoded", 32'(pad_decoded), 32'd0);
        check("abort_frame_done", 32'(frame_done), 32'd0);
        reset = 1'b0;
        model_reset();
        dones = 0;
        repeat (40) begin
            tick();
            if (frame_done === 1'b1) dones++;
        end
        check("abort_no_frame_done", 32'(dones), 32'd0);
        predict_frame();
        wait_frame();

        repeat (4) tick();
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
